// File: rtl/alu_32b_exec.sv
// alu_32b_exec: opcode decode, ALU control, 32-bit ALU and the registered EX stage.
// Control, ALU result and flags are combinational; the ex_* bundle is registered one cycle later.
module alu_32b_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        SignZero,
    output logic [1:0]  ALUOp,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        overflow,
    output logic [31:0] ex_result,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_write_reg,
    output logic        ex_zero,
    output logic        ex_overflow,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_read,
    output logic        ex_mem_write
);
    logic [10:0] ctrl;
    logic [3:0]  funct_ctl;
    logic [31:0] imm_ext, op_b, sum, diff;
    logic        add_ovf, sub_ovf;
    logic [4:0]  write_reg;
    logic [74:0] ex_d, ex_q;
    logic        unused_rs;

    assign unused_rs = ^instr[25:21];

    always_comb begin
        case (instr[31:26])
            6'b000000: ctrl = 11'b10010000010;
            6'b100011: ctrl = 11'b01111000000;
            6'b101011: ctrl = 11'b01000100000;
            6'b000100: ctrl = 11'b00000010001;
            6'b001000: ctrl = 11'b01010000000;
            6'b001101: ctrl = 11'b01010000111;
            6'b000010: ctrl = 11'b00000001000;
            default:   ctrl = 11'b0;
        endcase
    end

    assign {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, SignZero, ALUOp} = ctrl;

    always_comb begin
        case (instr[5:0])
            6'b100010: funct_ctl = 4'b0110;
            6'b100100: funct_ctl = 4'b0000;
            6'b100101: funct_ctl = 4'b0001;
            6'b101010: funct_ctl = 4'b0111;
            6'b100111: funct_ctl = 4'b1100;
            default:   funct_ctl = 4'b0010;
        endcase
    end

    assign alu_control = ALUOp == 2'b00 ? 4'b0010 :
                         ALUOp == 2'b01 ? 4'b0110 :
                         ALUOp == 2'b11 ? 4'b0001 : funct_ctl;

    assign imm_ext = SignZero ? {16'b0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign op_b    = ALUSrc ? imm_ext : read_data2;
    assign sum     = read_data1 + op_b;
    assign diff    = read_data1 - op_b;
    assign add_ovf = (read_data1[31] == op_b[31]) && (sum[31] != read_data1[31]);
    assign sub_ovf = (read_data1[31] != op_b[31]) && (diff[31] != read_data1[31]);

    // slt uses a true signed compare so it stays correct when A-B overflows
    always_comb begin
        case (alu_control)
            4'b0010: alu_result = sum;
            4'b0110: alu_result = diff;
            4'b0000: alu_result = read_data1 & op_b;
            4'b0001: alu_result = read_data1 | op_b;
            4'b0111: alu_result = {31'b0, $signed(read_data1) < $signed(op_b)};
            4'b1100: alu_result = ~(read_data1 | op_b);
            default: alu_result = 32'b0;
        endcase
    end

    assign zero      = alu_result == 32'b0;
    assign overflow  = alu_control == 4'b0010 ? add_ovf : alu_control == 4'b0110 ? sub_ovf : 1'b0;
    assign write_reg = RegDst ? instr[15:11] : instr[20:16];

    assign ex_d = {alu_result, read_data2, write_reg, zero, overflow, RegWrite, MemtoReg, MemRead, MemWrite};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign {ex_result, ex_store_data, ex_write_reg, ex_zero, ex_overflow,
            ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write} = ex_q;
endmodule

// File: tb/tb_alu_32b_exec.sv
// tb_alu_32b_exec: directed steps; combinational outputs checked immediately, the ex_* bundle via an expected-value queue.
module tb_alu_32b_exec;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0, read_data1 = '0, read_data2 = '0;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, SignZero;
    logic [1:0]  ALUOp;
    logic [3:0]  alu_control;
    logic [31:0] alu_result, ex_result, ex_store_data;
    logic        zero, overflow;
    logic [4:0]  ex_write_reg;
    logic        ex_zero, ex_overflow, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;

    int checks = 0;
    int errors = 0;
    logic [74:0] sb[$];

    alu_32b_exec dut (
        .clk(clk), .reset(reset), .instr(instr), .read_data1(read_data1), .read_data2(read_data2),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .SignZero(SignZero),
        .ALUOp(ALUOp), .alu_control(alu_control), .alu_result(alu_result), .zero(zero),
        .overflow(overflow), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_zero(ex_zero), .ex_overflow(ex_overflow),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    function automatic logic [74:0] ex_bundle();
        return {ex_result, ex_store_data, ex_write_reg, ex_zero, ex_overflow,
                ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write};
    endfunction

    task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ctrl order: RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,SignZero,ALUOp[1:0]
    task automatic step(input string tag, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic [10:0] ctrl, input logic [3:0] aluc, input logic [31:0] res,
                        input logic z, input logic o, input logic [4:0] wr);
        logic [74:0] exp;
        instr = i; read_data1 = a; read_data2 = b;
        #1;
        chk({tag, "_ctrl"}, 75'({RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, SignZero, ALUOp}), 75'(ctrl));
        chk({tag, "_aluc"}, 75'(alu_control), 75'(aluc));
        chk({tag, "_res"}, 75'(alu_result), 75'(res));
        chk({tag, "_flags"}, 75'({zero, overflow}), 75'({z, o}));
        sb.push_back({res, b, wr, z, o, ctrl[7], ctrl[8], ctrl[6], ctrl[5]});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 75'(1), 75'(0));
        end else begin
            exp = sb.pop_front();
            chk({tag, "_ex"}, ex_bundle(), exp);
        end
    endtask

    initial begin
        #2;
        chk("reset_ex", ex_bundle(), '0);
        @(posedge clk);
        #1;
        chk("reset_hold", ex_bundle(), '0);
        reset = 1'b0;
        step("r_add", 32'h00221820, 32'd1, 32'd2, 11'b10010000010, 4'b0010, 32'd3, 1'b0, 1'b0, 5'd3);
        step("lw", {6'b100011, 5'd2, 5'd5, 16'hFFFC}, 32'd8, 32'h1234, 11'b01111000000, 4'b0010, 32'd4, 1'b0, 1'b0, 5'd5);
        step("ori", {6'b001101, 5'd0, 5'd6, 16'hFFFC}, 32'd0, 32'h55, 11'b01010000111, 4'b0001, 32'h0000FFFC, 1'b0, 1'b0, 5'd6);
        step("beq_eq", {6'b000100, 5'd1, 5'd7, 16'h0003}, 32'd5, 32'd5, 11'b00000010001, 4'b0110, 32'd0, 1'b1, 1'b0, 5'd7);
        step("beq_ne", {6'b000100, 5'd1, 5'd7, 16'h0003}, 32'd5, 32'd6, 11'b00000010001, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd7);
        step("add_ovf", {6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 32'h7FFFFFFF, 32'd1, 11'b10010000010, 4'b0010, 32'h80000000, 1'b0, 1'b1, 5'd4);
        step("slt_ovf", {6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h2A}, 32'h80000000, 32'd1, 11'b10010000010, 4'b0111, 32'd1, 1'b0, 1'b0, 5'd8);
        step("slt_gt", {6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h2A}, 32'd1, 32'h80000000, 11'b10010000010, 4'b0111, 32'd0, 1'b1, 1'b0, 5'd8);
        step("sub_ovf", {6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h22}, 32'd0, 32'h80000000, 11'b10010000010, 4'b0110, 32'h80000000, 1'b0, 1'b1, 5'd9);
        step("and", {6'd0, 5'd1, 5'd2, 5'd10, 5'd0, 6'h24}, 32'hF0F0F0F0, 32'hFF00FF00, 11'b10010000010, 4'b0000, 32'hF000F000, 1'b0, 1'b0, 5'd10);
        step("nor", {6'd0, 5'd1, 5'd2, 5'd11, 5'd0, 6'h27}, 32'hF0F0F0F0, 32'h0F0F0F0F, 11'b10010000010, 4'b1100, 32'd0, 1'b1, 1'b0, 5'd11);
        step("funct_dflt", {6'd0, 5'd1, 5'd2, 5'd12, 5'd0, 6'h3F}, 32'd2, 32'd3, 11'b10010000010, 4'b0010, 32'd5, 1'b0, 1'b0, 5'd12);
        step("addi_sext", {6'b001000, 5'd1, 5'd13, 16'h8000}, 32'h10, 32'd0, 11'b01010000000, 4'b0010, 32'hFFFF8010, 1'b0, 1'b0, 5'd13);
        step("jump", {6'b000010, 5'd0, 5'd14, 16'h0000}, 32'd1, 32'd1, 11'b00000001000, 4'b0010, 32'd2, 1'b0, 1'b0, 5'd14);
        step("undef_op", {6'b111111, 5'd1, 5'd15, 16'h0004}, 32'd3, 32'd4, 11'b00000000000, 4'b0010, 32'd7, 1'b0, 1'b0, 5'd15);
        step("sw", {6'b101011, 5'd1, 5'd9, 16'h0010}, 32'h100, 32'hDEADBEEF, 11'b01000100000, 4'b0010, 32'h110, 1'b0, 1'b0, 5'd9);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_ex", ex_bundle(), '0);
        chk("async_reset_memwrite", 75'(MemWrite), 75'(1));
        #10;
        reset = 1'b0;
        chk("reset_release_hold", ex_bundle(), '0);
        @(posedge clk);
        #1;
        chk("after_release_sw", ex_bundle(), {32'h110, 32'hDEADBEEF, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
